// File: rtl/weight_store_stream_if.sv
// weight_store_stream_if: write stream and read-side bundle for the weight store.
// master drives words/params/release, slave is the store itself.
interface weight_store_stream_if #(
    parameter int INPUT_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAX_R        = 5,
    parameter int MAX_S        = 5
);
    logic                                  clear;
    logic                                  wr_valid;
    logic                                  wr_ready;
    logic [INPUT_WIDTH-1:0]                wr_data;
    logic [3:0]                            param_r;
    logic [3:0]                            param_s;
    logic                                  rd_release;
    logic                                  rd_valid;
    logic [MAX_R*MAX_S*WEIGHT_WIDTH-1:0]   rd_data;
    logic [3:0]                            rd_r;
    logic [3:0]                            rd_s;
    logic                                  load_done;

    modport master (
        output clear, wr_valid, wr_data, param_r, param_s, rd_release,
        input  wr_ready, rd_valid, rd_data, rd_r, rd_s, load_done
    );

    modport slave (
        input  clear, wr_valid, wr_data, param_r, param_s, rd_release,
        output wr_ready, rd_valid, rd_data, rd_r, rd_s, load_done
    );
endinterface

// File: rtl/weight_store_stream.sv
// weight_store_stream: packs a word stream of weights into an R x S filter.
// Define WSTORE_DOUBLE_BUFFER_EN for separate write/read banks (LOAD/HOLD).
module weight_store_stream #(
    parameter int INPUT_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAX_R        = 5,
    parameter int MAX_S        = 5
) (
    input logic                   clk,
    input logic                   reset,
    weight_store_stream_if.slave  bus
);
    localparam int LANES  = INPUT_WIDTH / WEIGHT_WIDTH;
    localparam int CELLS  = MAX_R * MAX_S;
    localparam int BANK_W = CELLS * WEIGHT_WIDTH;

    logic [BANK_W-1:0] wbank;
    logic [BANK_W-1:0] nbank;
    logic [7:0]        cnt;
    logic [7:0]        ncnt;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [3:0]        nrow;
    logic [3:0]        ncol;
    logic [3:0]        lat_r;
    logic [3:0]        lat_s;
    logic [3:0]        eff_r;
    logic [3:0]        eff_s;
    logic [3:0]        rd_r;
    logic [3:0]        rd_s;
    logic              rd_valid;
    logic              load_done;
    logic              busy;
    logic              last;
    logic              accept;
    logic              release_ok;

    function automatic int clamp(input logic [3:0] v, input int lim);
        if (v == 4'd0)
            return 1;
        if (int'(v) > lim)
            return lim;
        return int'(v);
    endfunction

`ifdef WSTORE_DOUBLE_BUFFER_EN
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state;
    logic [BANK_W-1:0] rbank;

    assign bus.wr_ready = (state == ST_LOAD);
    assign bus.rd_data  = rbank;
`else
    assign bus.wr_ready = ~rd_valid;
    assign bus.rd_data  = wbank;
`endif

    assign bus.rd_valid  = rd_valid;
    assign bus.rd_r      = rd_r;
    assign bus.rd_s      = rd_s;
    assign bus.load_done = load_done;

    assign busy       = (cnt != 8'd0);
    assign accept     = bus.wr_valid & bus.wr_ready;
    assign release_ok = bus.rd_release & rd_valid;

    // Scatter the lanes of the incoming word into the bank, row-major.
    always_comb begin
        int r;
        int c;
        int n;
        int er;
        int es;
        int pos;
        eff_r = busy ? lat_r : 4'(clamp(bus.param_r, MAX_R));
        eff_s = busy ? lat_s : 4'(clamp(bus.param_s, MAX_S));
        er    = int'(eff_r);
        es    = int'(eff_s);
        nbank = busy ? wbank : '0;
        r     = busy ? int'(row) : 0;
        c     = busy ? int'(col) : 0;
        n     = busy ? int'(cnt) : 0;
        pos   = 0;
        for (int l = 0; l < LANES; l++) begin
            if (n < er * es) begin
                pos = r * MAX_S + c;
                nbank[(CELLS-1-pos)*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    bus.wr_data[(LANES-1-l)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                n = n + 1;
                if (c == es - 1) begin
                    c = 0;
                    r = r + 1;
                end else begin
                    c = c + 1;
                end
            end
        end
        last = (n == er * es);
        ncnt = 8'(n);
        nrow = 4'(r);
        ncol = 4'(c);
    end

    // Write counters, bank hand-off to the read side and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbank     <= '0;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            lat_r     <= '0;
            lat_s     <= '0;
            rd_r      <= '0;
            rd_s      <= '0;
            rd_valid  <= 1'b0;
            load_done <= 1'b0;
`ifdef WSTORE_DOUBLE_BUFFER_EN
            rbank     <= '0;
            state     <= ST_LOAD;
`endif
        end else begin
            load_done <= 1'b0;
            if (release_ok)
                rd_valid <= 1'b0;
            if (bus.clear) begin
                cnt <= '0;
                row <= '0;
                col <= '0;
`ifdef WSTORE_DOUBLE_BUFFER_EN
                state <= ST_LOAD;
`endif
            end else if (accept) begin
                wbank <= nbank;
                lat_r <= eff_r;
                lat_s <= eff_s;
                if (last) begin
                    cnt       <= '0;
                    row       <= '0;
                    col       <= '0;
                    load_done <= 1'b1;
`ifdef WSTORE_DOUBLE_BUFFER_EN
                    if (!rd_valid || release_ok) begin
                        rbank    <= nbank;
                        rd_r     <= eff_r;
                        rd_s     <= eff_s;
                        rd_valid <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                    end
`else
                    rd_r     <= eff_r;
                    rd_s     <= eff_s;
                    rd_valid <= 1'b1;
`endif
                end else begin
                    cnt <= ncnt;
                    row <= nrow;
                    col <= ncol;
                end
            end
`ifdef WSTORE_DOUBLE_BUFFER_EN
            if (state == ST_HOLD && release_ok && !bus.clear) begin
                rbank    <= wbank;
                rd_r     <= lat_r;
                rd_s     <= lat_s;
                rd_valid <= 1'b1;
                state    <= ST_LOAD;
            end
`endif
        end
    end
endmodule

// File: tb/tb_weight_store_stream.sv
// tb_weight_store_stream: vector table, corner sequences and random traffic
// against a queue-based filter model (both buffer configurations).
module tb_weight_store_stream;
    localparam int IW    = 32;
    localparam int WW    = 8;
    localparam int MR    = 5;
    localparam int MS    = 5;
    localparam int LANES = IW / WW;
    localparam int DW    = MR * MS * WW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    weight_store_stream_if #(
        .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .MAX_R(MR), .MAX_S(MS)
    ) bus ();

    weight_store_stream #(
        .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .MAX_R(MR), .MAX_S(MS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0]        r;
        logic [3:0]        s;
        logic [3:0]        er;
        logic [3:0]        es;
        logic [3:0]        nw;
        logic [6:0][31:0]  w;
        logic [4:0][39:0]  row;
    } vec_t;

    vec_t tab [4];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] m_rd   [MR][MS];
    logic [7:0] m_held [MR][MS];
    logic       m_valid;
    logic       m_hold;
    logic       m_done;
    int         m_r, m_s, h_r, h_s, p_r, p_s;
    logic [7:0] pend [$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampd(input int v, input int lim);
        return (v == 0) ? 1 : ((v > lim) ? lim : v);
    endfunction

    function automatic logic exp_ready();
`ifdef WSTORE_DOUBLE_BUFFER_EN
        return !m_hold;
`else
        return !m_valid;
`endif
    endfunction

    function automatic logic [DW-1:0] model_flat();
        logic [DW-1:0] v = '0;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MS; c++)
                v[(MR*MS-1-(r*MS+c))*WW +: WW] = m_rd[r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MS; c++) begin
                m_rd[r][c]   = '0;
                m_held[r][c] = '0;
            end
        m_valid = 0; m_hold = 0; m_done = 0;
        m_r = 0; m_s = 0; h_r = 0; h_s = 0; p_r = 1; p_s = 1;
        pend.delete();
    endtask

    // Advance the reference by one clock using the inputs now on the bus.
    task automatic model_step();
        logic acc, rel, was_valid, was_hold, ld;
        logic [7:0] f [MR][MS];
        acc = bus.wr_valid && exp_ready();
        rel = bus.rd_release && m_valid;
        was_valid = m_valid;
        was_hold  = m_hold;
        ld = 0;
        if (rel) m_valid = 0;
        if (bus.clear) begin
            pend.delete();
            m_hold = 0;
        end else if (acc) begin
            if (pend.size() == 0) begin
                p_r = clampd(int'(bus.param_r), MR);
                p_s = clampd(int'(bus.param_s), MS);
            end
            for (int l = 0; l < LANES; l++)
                if (pend.size() < p_r * p_s)
                    pend.push_back(bus.wr_data[(LANES-1-l)*WW +: WW]);
            if (pend.size() == p_r * p_s) begin
                ld = 1;
                for (int r = 0; r < MR; r++)
                    for (int c = 0; c < MS; c++)
                        f[r][c] = '0;
                for (int k = 0; k < p_r * p_s; k++)
                    f[k / p_s][k % p_s] = pend[k];
                pend.delete();
`ifdef WSTORE_DOUBLE_BUFFER_EN
                if (was_valid && !rel) begin
                    m_held = f; h_r = p_r; h_s = p_s; m_hold = 1;
                end else begin
                    m_rd = f; m_r = p_r; m_s = p_s; m_valid = 1;
                end
`else
                m_rd = f; m_r = p_r; m_s = p_s; m_valid = 1;
`endif
            end
        end
`ifdef WSTORE_DOUBLE_BUFFER_EN
        if (was_hold && rel && !bus.clear) begin
            m_rd = m_held; m_r = h_r; m_s = h_s; m_valid = 1; m_hold = 0;
        end
`endif
        m_done = ld;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rd_valid", DW'(bus.rd_valid), DW'(m_valid));
        check("wr_ready", DW'(bus.wr_ready), DW'(exp_ready()));
        check("load_done", DW'(bus.load_done), DW'(m_done));
        if (m_valid) begin
            check("rd_r", DW'(bus.rd_r), DW'(m_r));
            check("rd_s", DW'(bus.rd_s), DW'(m_s));
            check("rd_data", bus.rd_data, model_flat());
        end
    endtask

    task automatic do_reset();
        bus.wr_valid = 0; bus.clear = 0; bus.rd_release = 0;
        bus.wr_data = '0; bus.param_r = '0; bus.param_s = '0;
        reset = 1;
        #2;
        check("rst_rd_valid", DW'(bus.rd_valid), '0);
        check("rst_load_done", DW'(bus.load_done), '0);
        check("rst_rd_data", bus.rd_data, '0);
        check("rst_rd_rs", DW'({bus.rd_r, bus.rd_s}), '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        check("rst_wr_ready", DW'(bus.wr_ready), DW'(1));
    endtask

    task automatic send_words(input logic [3:0] r, input logic [3:0] s,
                              input logic [6:0][31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            bus.wr_valid = 1; bus.wr_data = w[i];
            bus.param_r = r; bus.param_s = s;
            while (!bus.wr_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (!bus.wr_ready) check("ready_timeout", DW'(0), DW'(1));
            tick();
        end
        bus.wr_valid = 0;
    endtask

    task automatic check_rows(input string tag, input vec_t v);
        for (int i = 0; i < MR; i++)
            check($sformatf("%s_row%0d", tag, i),
                  DW'(bus.rd_data[(MR-1-i)*40 +: 40]), DW'(v.row[i]));
    endtask

    task automatic release_once();
        bus.rd_release = 1;
        tick();
        bus.rd_release = 0;
    endtask

    initial begin
        vec_t junk;
        for (int k = 0; k < 4; k++) tab[k] = '0;
        tab[0].r = 5; tab[0].s = 5; tab[0].er = 5; tab[0].es = 5; tab[0].nw = 7;
        for (int i = 0; i < 7; i++)
            tab[0].w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        tab[0].row[0] = 40'h0001020304; tab[0].row[1] = 40'h0506070809;
        tab[0].row[2] = 40'h0A0B0C0D0E; tab[0].row[3] = 40'h0F10111213;
        tab[0].row[4] = 40'h1415161718;
        tab[1].r = 3; tab[1].s = 4; tab[1].er = 3; tab[1].es = 4; tab[1].nw = 3;
        tab[1].w[0] = 32'hA0A1A2A3; tab[1].w[1] = 32'hB0B1B2B3;
        tab[1].w[2] = 32'hC0C1C2C3;
        tab[1].row[0] = 40'hA0A1A2A300; tab[1].row[1] = 40'hB0B1B2B300;
        tab[1].row[2] = 40'hC0C1C2C300;
        tab[2].r = 0; tab[2].s = 9; tab[2].er = 1; tab[2].es = 5; tab[2].nw = 2;
        tab[2].w[0] = 32'h11223344; tab[2].w[1] = 32'h55667788;
        tab[2].row[0] = 40'h1122334455;
        tab[3].r = 2; tab[3].s = 2; tab[3].er = 2; tab[3].es = 2; tab[3].nw = 1;
        tab[3].w[0] = 32'hDEADBEEF;
        tab[3].row[0] = 40'hDEAD000000; tab[3].row[1] = 40'hBEEF000000;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_words(tab[v].r, tab[v].s, tab[v].w, int'(tab[v].nw));
            check($sformatf("v%0d_done", v), DW'(bus.load_done), DW'(1));
            check($sformatf("v%0d_valid", v), DW'(bus.rd_valid), DW'(1));
            check($sformatf("v%0d_r", v), DW'(bus.rd_r), DW'(tab[v].er));
            check($sformatf("v%0d_s", v), DW'(bus.rd_s), DW'(tab[v].es));
            check_rows($sformatf("v%0d", v), tab[v]);
            tick();
            check($sformatf("v%0d_pulse", v), DW'(bus.load_done), DW'(0));
        end

        // Clear part way, with a word offered in the same cycle.
        do_reset();
        junk = '0;
        for (int i = 0; i < 7; i++) junk.w[i] = 32'hEEEEEEEE;
        send_words(4'd5, 4'd5, junk.w, 3);
        bus.clear = 1; bus.wr_valid = 1; bus.wr_data = 32'hFFFFFFFF;
        tick();
        bus.clear = 0; bus.wr_valid = 0;
        send_words(4'd5, 4'd5, tab[0].w, 7);
        check_rows("clr", tab[0]);
        bus.clear = 1;
        tick();
        bus.clear = 0;
        check("clr_keeps_valid", DW'(bus.rd_valid), DW'(1));
        check_rows("clr_keep", tab[0]);

        // Reset in the middle of a load, then a clean load.
        send_words(4'd5, 4'd5, junk.w, 0);
        release_once();
        send_words(4'd5, 4'd5, junk.w, 3);
        do_reset();
        send_words(4'd3, 4'd4, tab[1].w, 3);
        check_rows("rst_mid", tab[1]);

        // Parameters moving mid-load are ignored.
        release_once();
        bus.wr_valid = 1; bus.wr_data = tab[0].w[0];
        bus.param_r = 5; bus.param_s = 5;
        tick();
        for (int i = 1; i < 7; i++) begin
            bus.wr_data = tab[0].w[i]; bus.param_r = 2; bus.param_s = 3;
            tick();
        end
        bus.wr_valid = 0;
        check_rows("param_mid", tab[0]);
        check("param_mid_r", DW'(bus.rd_r), DW'(5));

`ifdef WSTORE_DOUBLE_BUFFER_EN
        // Second filter completes while the first is held -> HOLD.
        send_words(4'd3, 4'd4, tab[1].w, 3);
        check("hold_ready", DW'(bus.wr_ready), DW'(0));
        check_rows("hold_keep", tab[0]);
        release_once();
        check("hold_rel_ready", DW'(bus.wr_ready), DW'(1));
        check("hold_rel_valid", DW'(bus.rd_valid), DW'(1));
        check_rows("hold_rel", tab[1]);
        // Release coincides with the last word: no HOLD, no bubble.
        bus.wr_valid = 1; bus.param_r = 0; bus.param_s = 9;
        bus.wr_data = tab[2].w[0];
        tick();
        check("same_mid_ready", DW'(bus.wr_ready), DW'(1));
        bus.wr_data = tab[2].w[1]; bus.rd_release = 1;
        tick();
        bus.wr_valid = 0; bus.rd_release = 0;
        check("same_ready", DW'(bus.wr_ready), DW'(1));
        check("same_valid", DW'(bus.rd_valid), DW'(1));
        check_rows("same", tab[2]);
`else
        check("single_block", DW'(bus.wr_ready), DW'(0));
        release_once();
        check("single_rel_valid", DW'(bus.rd_valid), DW'(0));
        check("single_rel_ready", DW'(bus.wr_ready), DW'(1));
        release_once();
        check("single_idle_rel", DW'(bus.rd_valid), DW'(0));
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.wr_valid   = ($urandom % 4) != 0;
            bus.wr_data    = $urandom;
            if (($urandom % 8) == 0) begin
                bus.param_r = 4'($urandom_range(0, 15));
                bus.param_s = 4'($urandom_range(0, 15));
            end
            bus.clear      = ($urandom % 40) == 0;
            bus.rd_release = ($urandom % 6) == 0;
            tick();
        end
        bus.wr_valid = 0; bus.clear = 0; bus.rd_release = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_store_stream.md
WEIGHT_STORE_STREAM -- requirements
Module: weight_store_stream

Interface
REQ-001 Parameter INPUT_WIDTH, default 32: write word width; SHALL be a multiple of WEIGHT_WIDTH.
REQ-002 Parameter WEIGHT_WIDTH, default 8: width of one weight.
REQ-003 Parameter MAX_R, default 5: maximum filter height (rows held).
REQ-004 Parameter MAX_S, default 5: maximum filter width (weights per row).
REQ-005 CLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 CLEAR  in  1  synchronous abort of any partial load.
REQ-008 WR_VALID  in  1  write word valid.
REQ-009 WR_READY  out  1  store can accept a word this cycle.
REQ-010 WR_DATA  in  INPUT_WIDTH  packed weights; first weight in the MSBs.
REQ-011 PARAM_R  in  4  filter height, sampled on the first word of each filter.
REQ-012 PARAM_S  in  4  filter width, sampled with PARAM_R.
REQ-013 RD_RELEASE  in  1  consumer finished with the current filter.
REQ-014 RD_VALID  out  1  RD_DATA holds a complete filter.
REQ-015 RD_DATA  out  MAX_R*MAX_S*WEIGHT_WIDTH  row 0 in the MSBs; each row is MAX_S*WEIGHT_WIDTH bits with weight col 0 in the MSBs.
REQ-016 RD_R, RD_S  out  4 each  effective dimensions of the filter on RD_DATA.
REQ-017 LOAD_DONE  out  1  one-cycle pulse when a filter load completes.

Function
REQ-018 A word SHALL be accepted only when WR_VALID and WR_READY are both high at a rising edge.
REQ-019 Effective dimensions SHALL be clamped: a value of 0 becomes 1; a value above MAX_R (or MAX_S) becomes MAX_R (or MAX_S).
REQ-020 Each word SHALL carry LANES = INPUT_WIDTH/WEIGHT_WIDTH weights, taken MSB lane first.
REQ-021 Weights SHALL be written row-major as one continuous stream: col increments per weight; at col = S-1 the next weight goes to col 0 of row+1; words are not realigned at row boundaries.
REQ-022 A filter SHALL need ceil(R*S/LANES) words; lanes of the final word beyond weight R*S-1 SHALL be discarded.
REQ-023 Row positions at col >= S and rows >= R SHALL read as zero.
REQ-024 Throughput SHALL be one word per cycle while WR_READY is high.
REQ-025 States: LOAD (accepting words) and HOLD (write bank complete, waiting for a free read bank).
REQ-026 LOAD -> HOLD when the last word of a filter is accepted and the read bank is occupied; otherwise stay in LOAD and present the filter to the read side.
REQ-027 HOLD -> LOAD on RD_RELEASE; WR_READY SHALL be 0 in HOLD.
REQ-028 LOAD_DONE SHALL pulse in the cycle after the last word is accepted (latency 1).
REQ-029 When the read bank is free at completion, RD_VALID SHALL rise in that same following cycle.
REQ-030 RD_RELEASE with RD_VALID low SHALL be ignored.
REQ-031 RD_RELEASE in the same cycle as the last accepted word SHALL free the read bank and load the new filter directly (RD_VALID stays 1 and RD_DATA updates); the block SHALL NOT enter HOLD.
REQ-032 CLEAR SHALL discard the partial load, zero the write counters and return to LOAD; it SHALL NOT affect RD_VALID or RD_DATA.
REQ-033 CLEAR while in HOLD SHALL discard the held filter.
REQ-034 CLEAR SHALL take priority over an accepted word in the same cycle.
REQ-035 PARAM_R and PARAM_S changes in the middle of a load SHALL be ignored.

Reset
REQ-036 RESET SHALL asynchronously clear all banks, counters, RD_DATA, RD_R, RD_S, RD_VALID and LOAD_DONE to 0, and set the state to LOAD.
REQ-037 WR_READY SHALL be 1 after reset is released.
REQ-038 RESET during a load SHALL discard the partial filter.

Configuration
REQ-039 With macro WSTORE_DOUBLE_BUFFER_EN defined, there SHALL be separate write and read banks; a new filter loads while RD_DATA holds the previous one, and the behaviour of REQ-026/027 applies.
REQ-040 Without WSTORE_DOUBLE_BUFFER_EN, there SHALL be one bank and RD_DATA SHALL show it live:
- WR_READY SHALL be 0 whenever RD_VALID is 1;
- RD_RELEASE SHALL clear RD_VALID and re-enable writes on the next cycle;
- HOLD SHALL never be entered.

Verification
REQ-041 R=5, S=5, default widths, words 0x00010203 ... (7 words) -> LOAD_DONE 1 cycle after the 7th word; row0 = 0x0001020304; row4 = 0x1415161718; last 3 lanes of word 7 discarded.
REQ-042 R=3, S=4, 3 words 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 -> rows 0xA0A1A2A300, 0xB0B1B2B300, 0xC0C1C2C300; rows 3-4 zero; RD_R=3, RD_S=4.
REQ-043 Double buffer enabled, second filter completes while RD_VALID=1 -> HOLD with WR_READY=0; RD_RELEASE -> RD_DATA updates next cycle and WR_READY returns to 1.
REQ-044 Double buffer enabled, RD_RELEASE in the same cycle as the last word -> no HOLD and no bubble on WR_READY.
REQ-045 PARAM_R=0, PARAM_S=9 -> clamped to R=1, S=5; 2 words load the filter; second word's lanes 1-3 discarded.
REQ-046 CLEAR after 3 of 7 words, then a fresh 7-word load -> RD_DATA holds only the fresh filter; RESET mid-load -> all outputs 0 and WR_READY=1.
